// File: rtl/keypad_matrix_scan_if.sv
// keypad_matrix_scan_if
//   Bundles the keypad scanner's matrix and key-event signals.
//   slave  : the scanner (samples scan_en/key_row, drives column strobe and key outputs)
//   master : the surrounding logic / keypad model (drives scan_en and the row returns)
// Signals:
//   scan_en   1  scanning enable
//   key_row   4  row returns, active-high, asynchronous
//   key_col   4  column strobe, one-hot active-high
//   key_code  4  last accepted key {col_idx, row_idx}
//   key_valid 1  one-cycle pulse per accepted key event
//   key_held  1  accepted key currently considered pressed
interface keypad_matrix_scan_if;
  logic       scan_en;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output scan_en,
    output key_row,
    input  key_col,
    input  key_code,
    input  key_valid,
    input  key_held
  );

  modport slave (
    input  scan_en,
    input  key_row,
    output key_col,
    output key_code,
    output key_valid,
    output key_held
  );
endinterface

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan
//   Scans a 4x4 key matrix: strobes one column at a time, samples the synchronized row returns
//   into a 16-bit frame snapshot, debounces whole frames and emits one-cycle key events with a
//   4-bit key code {col_idx, row_idx}. Frames with more than one key pressed are never accepted.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  keypad_matrix_scan_if.slave (scan_en, key_row in; key_col, key_code, key_valid,
//        key_held out)
// Configuration:
//   KEYPAD_REPEAT_EN  when defined, a held key produces auto-repeat events after REPEAT_DELAY
//                     frames and then every REPEAT_RATE frames.
module keypad_matrix_scan #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_RATE     = 4
) (
  input logic                 clk,
  input logic                 rst,
  keypad_matrix_scan_if.slave bus
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_FRAMES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  // SCAN_DIV >= 3 lets the 2-FF row synchronizer settle within one column dwell.
  localparam bit ParamsOk = (SCAN_DIV >= 3) && (DEBOUNCE_FRAMES >= 1) &&
                            (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);

  if (!ParamsOk) begin : gen_param_check
    $error("keypad_matrix_scan: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

  // Scan datapath
  logic [3:0]      row_meta_q, row_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      key_col_q, key_col_d;
  logic [15:0]     snap_q, snap_d;
  logic            tick, frame_end;
  logic [15:0]     frame;
  logic            frame_single;
  logic [3:0]      frame_code;

  // Debounce FSM and outputs
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic            cand_in;
  logic            accept;
  logic            rep_fire;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;

  assign tick      = bus.scan_en && (div_q == DivLast);
  assign frame_end = tick && (col_idx_q == 2'd3);

  // The column sampled on this tick is not in snap_q yet, so splice it in for classification.
  always_comb begin
    frame = snap_q;
    frame[{col_idx_q, 2'b00} +: 4] = row_sync_q;
  end

  always_comb begin
    frame_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) frame_code = 4'(i);
    end
    frame_single = (frame != 16'd0) && ((frame & (frame - 16'd1)) == 16'd0);
  end

  assign cand_in = frame[cand_q];

  always_comb begin
    div_d     = div_q;
    col_idx_d = col_idx_q;
    snap_d    = snap_q;
    key_col_d = key_col_q;
    if (!bus.scan_en) begin
      div_d     = '0;
      col_idx_d = 2'd0;
      snap_d    = 16'd0;
      key_col_d = 4'b0000;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        snap_d[{col_idx_q, 2'b00} +: 4] = row_sync_q;
        col_idx_d = col_idx_q + 2'd1;
      end
      key_col_d = 4'b0001 << col_idx_d;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q  <= 4'd0;
      row_sync_q  <= 4'd0;
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      key_col_q   <= 4'b0001;
      snap_q      <= 16'd0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= bus.key_row;
      row_sync_q  <= row_meta_q;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      key_col_q   <= key_col_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic; only frame ends move the FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (!bus.scan_en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (frame_single) begin
            cand_d = frame_code;
            if (CntDone == CntOne) begin
              accept  = 1'b1;
              state_d = StPressed;
              cnt_d   = '0;
            end else begin
              state_d = StDebounce;
              cnt_d   = CntOne;
            end
          end
        end
        StDebounce: begin
          if (frame_single && (frame_code == cand_q)) begin
            if (cnt_q + CntOne == CntDone) begin
              accept  = 1'b1;
              state_d = StPressed;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StPressed: begin
          // Extra keys are ignored; only the accepted key's bit matters here.
          if (!cand_in) begin
            if (CntDone == CntOne) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              state_d = StRelease;
              cnt_d   = CntOne;
            end
          end
        end
        StRelease: begin
          if (cand_in) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_q + CntOne == CntDone) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelay = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepRate  = RepW'(REPEAT_RATE);

  logic [RepW-1:0] rep_q, rep_d;
  logic            rep_armed_q, rep_armed_d;

  // rep restarts from zero after each repeat; rep_armed selects the initial delay or the rate.
  always_comb begin
    rep_d       = rep_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    if (!bus.scan_en || accept) begin
      rep_d       = '0;
      rep_armed_d = 1'b0;
    end else if (frame_end && (state_q == StPressed) && cand_in) begin
      rep_d = rep_q + 1'b1;
      if (rep_d == (rep_armed_q ? RepRate : RepDelay)) begin
        rep_fire    = 1'b1;
        rep_d       = '0;
        rep_armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Registered outputs, updated on the edge that closes the frame
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (accept) key_code_d = cand_d;
    if (bus.scan_en) key_valid_d = accept | rep_fire;
    key_held_d = bus.scan_en && ((state_d == StPressed) || (state_d == StRelease));
  end

  assign bus.key_col   = key_col_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan
//   Keypad matrix model driving row returns from the column strobe; expected key codes are
//   queued when a press is applied and popped/compared whenever key_valid pulses.
module tb_keypad_matrix_scan;
  localparam int Frame = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pressed;
  logic [3:0]  sb[$];
  logic [3:0]  mon_exp;
  logic        prev_valid;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_events = 0;
  int          base;
  int          cycles;
  bit          seen;

  always #5 clk = ~clk;

  keypad_matrix_scan_if bus ();

  keypad_matrix_scan #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3),
    .REPEAT_DELAY    (8),
    .REPEAT_RATE     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Key at code c*4+r connects column c to row r while pressed.
  always_comb begin
    bus.key_row = 4'd0;
    for (int c = 0; c < 4; c++) begin
      if (bus.key_col[c]) bus.key_row = bus.key_row | pressed[c*4 +: 4];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int bound, output bit found, output int elapsed);
    found   = 1'b0;
    elapsed = 0;
    while (!found && elapsed < bound) begin
      @(negedge clk);
      elapsed++;
      found = bus.key_valid;
    end
  endtask

  task automatic wait_release(input int bound, output bit found);
    int elapsed;
    found   = 1'b0;
    elapsed = 0;
    while (!found && elapsed < bound) begin
      @(negedge clk);
      elapsed++;
      found = !bus.key_held;
    end
  endtask

  // Scoreboard consumer
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.key_valid) begin
          n_events++;
          check_eq("valid_back_to_back", 32'(prev_valid), 32'd0);
          check_eq("sb_has_expect", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            check_eq("sb_key_code", 32'(bus.key_code), 32'(mon_exp));
          end
        end
        prev_valid = bus.key_valid;
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.scan_en = 1'b1;
    pressed     = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_key_col", 32'(bus.key_col), 32'h1);
    check_eq("rst_key_code", 32'(bus.key_code), 32'h0);
    check_eq("rst_key_valid", 32'(bus.key_valid), 32'h0);
    check_eq("rst_key_held", 32'(bus.key_held), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2 * Frame);

    // Single key 6 held 10 frames, then released
    base    = n_events;
    pressed = 16'd1 << 6;
    sb.push_back(4'd6);
    wait_valid(4 * Frame + 3, seen, cycles);
    check_eq("k6_valid_latency", 32'(seen), 32'd1);
    wait_cycles(10 * Frame - cycles);
    check_eq("k6_events", 32'(n_events - base), 32'd1);
    check_eq("k6_code", 32'(bus.key_code), 32'd6);
    check_eq("k6_held", 32'(bus.key_held), 32'd1);
    pressed = 16'd0;
    wait_release(4 * Frame, seen);
    check_eq("k6_release_latency", 32'(seen), 32'd1);
    wait_cycles(2 * Frame);
    check_eq("k6_no_extra", 32'(n_events - base), 32'd1);

    // Key 11 bouncing one frame at a time never debounces
    base    = n_events;
    pressed = 16'd1 << 11;
    wait_cycles(Frame);
    pressed = 16'd0;
    wait_cycles(Frame);
    pressed = 16'd1 << 11;
    wait_cycles(Frame);
    pressed = 16'd0;
    wait_cycles(5 * Frame);
    check_eq("k11_bounce_events", 32'(n_events - base), 32'd0);
    check_eq("k11_bounce_held", 32'(bus.key_held), 32'd0);
    check_eq("k11_code_kept", 32'(bus.key_code), 32'd6);

    // Keys 1 and 9 together are rejected; 9 alone is accepted
    base    = n_events;
    pressed = (16'd1 << 1) | (16'd1 << 9);
    wait_cycles(5 * Frame);
    check_eq("multi_events", 32'(n_events - base), 32'd0);
    check_eq("multi_held", 32'(bus.key_held), 32'd0);
    pressed = 16'd1 << 9;
    sb.push_back(4'd9);
    wait_valid(4 * Frame + 3, seen, cycles);
    check_eq("k9_valid_latency", 32'(seen), 32'd1);
    wait_cycles(3 * Frame);
    check_eq("k9_events", 32'(n_events - base), 32'd1);
    check_eq("k9_code", 32'(bus.key_code), 32'd9);
    pressed = 16'd0;
    wait_cycles(5 * Frame);
    check_eq("k9_released", 32'(bus.key_held), 32'd0);

    // Key 3 accepted, scanning paused and resumed with the key still held
    base    = n_events;
    pressed = 16'd1 << 3;
    sb.push_back(4'd3);
    wait_valid(4 * Frame + 3, seen, cycles);
    check_eq("k3_valid_latency", 32'(seen), 32'd1);
    wait_cycles(2 * Frame);
    bus.scan_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("dis_key_col", 32'(bus.key_col), 32'h0);
    check_eq("dis_key_held", 32'(bus.key_held), 32'h0);
    check_eq("dis_key_code", 32'(bus.key_code), 32'd3);
    wait_cycles(2 * Frame);
    check_eq("dis_key_col_late", 32'(bus.key_col), 32'h0);
    check_eq("dis_key_code_late", 32'(bus.key_code), 32'd3);
    check_eq("dis_events", 32'(n_events - base), 32'd1);
    bus.scan_en = 1'b1;
    sb.push_back(4'd3);
    wait_valid(3 * Frame + 3, seen, cycles);
    check_eq("reen_valid_latency", 32'(seen), 32'd1);
    check_eq("reen_not_early", 32'(cycles > 2 * Frame), 32'd1);
    check_eq("reen_events", 32'(n_events - base), 32'd2);
    pressed = 16'd0;
    wait_cycles(5 * Frame);

    // Key 5 held 20 frames past its first event
    base    = n_events;
    pressed = 16'd1 << 5;
    sb.push_back(4'd5);
`ifdef KEYPAD_REPEAT_EN
    repeat (4) sb.push_back(4'd5);
`endif
    wait_valid(4 * Frame + 3, seen, cycles);
    check_eq("k5_valid_latency", 32'(seen), 32'd1);
    wait_cycles(20 * Frame + 8);
`ifdef KEYPAD_REPEAT_EN
    check_eq("k5_events", 32'(n_events - base), 32'd5);
`else
    check_eq("k5_events", 32'(n_events - base), 32'd1);
`endif
    pressed = 16'd0;
    wait_cycles(5 * Frame);
    check_eq("k5_released", 32'(bus.key_held), 32'd0);

    // Reset asserted mid-scan while a key is held
    pressed = 16'd1 << 3;
    sb.push_back(4'd3);
    wait_valid(4 * Frame + 3, seen, cycles);
    check_eq("k3b_valid_latency", 32'(seen), 32'd1);
    wait_cycles(5);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_key_col", 32'(bus.key_col), 32'h1);
    check_eq("mid_rst_key_code", 32'(bus.key_code), 32'h0);
    check_eq("mid_rst_key_valid", 32'(bus.key_valid), 32'h0);
    check_eq("mid_rst_key_held", 32'(bus.key_held), 32'h0);
    pressed = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2 * Frame);
    check_eq("post_rst_held", 32'(bus.key_held), 32'h0);
    check_eq("post_rst_code", 32'(bus.key_code), 32'h0);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
